// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, constants and FSM encoding for the fetch stage
package inst_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

    function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - synchronous FIFO with push, pop and priority flush; head is read combinationally
module inst_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [CW-1:0]    count_q;

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en_i) begin
            if (flush_i) begin
                rd_q    <= '0;
                wr_q    <= '0;
                count_q <= '0;
            end else begin
                if (push_i) begin
                    mem_q[wr_q] <= data_i;
                    wr_q        <= wr_q + AW'(1);
                end
                if (pop_i) begin
                    rd_q <= rd_q + AW'(1);
                end
                case ({push_i, pop_i})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch: PC, request FSM, redirect/kill handling, queue to decode
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000,
    parameter int                     QDEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    output logic                   inst_re,
    output logic [InstAddrBus-1:0] inst_raddr,
    input  logic [InstBus-1:0]     inst_rdata,
    input  logic                   inst_busy,
    input  logic                   br_taken,
    input  logic [InstAddrBus-1:0] br_target,
    input  logic                   id_stall,
    output logic                   if_valid,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst
);

    localparam int CW = $clog2(QDEPTH) + 1;

    if_state_e              state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstAddrBus-1:0] raddr_q, raddr_d;
    logic                   re_q, re_d;
    logic                   kill_q, kill_d;
    logic                   push;
    logic                   pop;
    logic [CW-1:0]          count;
    logic [InstAddrBus+InstBus-1:0] head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IF_IDLE;
            pc_q    <= RESET_PC;
            raddr_q <= RESET_PC;
            re_q    <= 1'b0;
            kill_q  <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            raddr_q <= raddr_d;
            re_q    <= re_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        raddr_d = raddr_q;
        re_d    = re_q;
        kill_d  = kill_q;
        push    = 1'b0;
        case (state_q)
            IF_IDLE: begin
                // A redirect in IDLE must not issue the stale PC; the target goes out next cycle.
                if (!br_taken && count < CW'(QDEPTH)) begin
                    state_d = IF_REQ;
                    re_d    = 1'b1;
                    raddr_d = pc_q;
                end
            end
            IF_REQ: begin
                state_d = IF_WAIT;
                re_d    = 1'b0;
                pc_d    = pc_q + 32'd4;
            end
            IF_WAIT: begin
                if (!inst_busy) begin
                    state_d = IF_IDLE;
                    kill_d  = 1'b0;
                    push    = !kill_q;
                end
            end
            default: state_d = IF_IDLE;
        endcase
        // Kill only a transaction that is still outstanding after this edge.
        if (br_taken) begin
            pc_d = align_word(br_target);
            push = 1'b0;
            if (state_q == IF_REQ || (state_q == IF_WAIT && inst_busy)) begin
                kill_d = 1'b1;
            end
        end
    end

    assign pop = if_valid && !id_stall && !br_taken;

    inst_queue #(
        .DEPTH(QDEPTH),
        .WIDTH(InstAddrBus + InstBus)
    ) u_queue (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (rdy),
        .push_i (push),
        .data_i ({raddr_q, inst_rdata}),
        .pop_i  (pop),
        .flush_i(br_taken),
        .count_o(count),
        .head_o (head)
    );

    assign inst_re    = re_q;
    assign inst_raddr = raddr_q;
    assign if_valid   = (count != '0);
    assign if_pc      = head[InstAddrBus+InstBus-1:InstBus];
    assign if_inst    = head[InstBus-1:0];

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized and directed self-checking bench for inst_fetch
module tb_inst_fetch;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst, rdy, inst_re, inst_busy, br_taken, id_stall, if_valid;
    logic [31:0] inst_raddr, inst_rdata, br_target, if_pc, if_inst;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .inst_re   (inst_re),
        .inst_raddr(inst_raddr),
        .inst_rdata(inst_rdata),
        .inst_busy (inst_busy),
        .br_taken  (br_taken),
        .br_target (br_target),
        .id_stall  (id_stall),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_inst   (if_inst)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: a fetch phase (0 idle, 1 request, 2 waiting) and a queue of {pc, inst}
    logic [31:0] m_pc, m_raddr;
    bit          m_re, m_kill, m_fresh;
    int          m_ph;
    logic [63:0] m_q[$];

    // memory responder
    bit          mem_pend;
    int          mem_left;
    logic [31:0] mem_addr;
    int          lat;

    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    bit          prev_re;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h0101};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_raddr = 32'h0;
        m_re    = 1'b0;
        m_kill  = 1'b0;
        m_ph    = 0;
        m_fresh = 1'b1;
        m_q.delete();
    endtask

    task automatic model_step(input bit r, input bit st, input bit b, input logic [31:0] t,
                              input bit rs, input bit busy, input logic [31:0] rd);
        int ph0;
        bit done, pop, push;
        if (rs) begin
            model_reset();
            return;
        end
        if (!r) return;
        ph0  = m_ph;
        done = (m_ph == 2) && !busy;
        pop  = (m_q.size() != 0) && !st;
        push = done && !m_kill;
        if (m_ph == 0 && !b && m_q.size() < QD) begin
            m_re = 1'b1; m_raddr = m_pc; m_ph = 1;
        end else if (m_ph == 1) begin
            m_re = 1'b0; m_pc = m_pc + 32'd4; m_ph = 2;
        end else if (done) begin
            m_ph = 0; m_kill = 1'b0;
        end
        if (b) begin
            m_q.delete();
            m_pc = t & 32'hFFFF_FFFC;
            if (ph0 == 1 || (ph0 == 2 && busy)) m_kill = 1'b1;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_raddr, rd});
                m_fresh = 1'b0;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit st, input bit b, input logic [31:0] t, input bit rs);
        rdy = r; id_stall = st; br_taken = b; br_target = t; rst = rs;
        if (mem_pend && mem_left == 0) begin
            inst_busy  = 1'b0;
            inst_rdata = mem_word(mem_addr);
        end else begin
            inst_busy  = mem_pend;
            inst_rdata = 32'hDEAD_BEEF;
        end
        if (r && !rs && !b && if_valid && !st) pop_log.push_back(if_pc);
        model_step(r, st, b, t, rs, inst_busy, inst_rdata);
        if (rs) begin
            mem_pend = 1'b0;
        end else if (r) begin
            if (mem_pend) begin
                if (mem_left > 0) mem_left--;
                else mem_pend = 1'b0;
            end else if (inst_re) begin
                mem_pend = 1'b1; mem_left = lat; mem_addr = inst_raddr;
            end
        end
        @(posedge clk);
        #1;
        if (inst_re && !prev_re) req_log.push_back(inst_raddr);
        prev_re = inst_re;
        chk("inst_re", inst_re, m_re);
        chk("inst_raddr", inst_raddr, m_raddr);
        chk("if_valid", if_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("if_pc", if_pc, m_q[0][63:32]);
            chk("if_inst", if_inst, m_q[0][31:0]);
        end else if (m_fresh) begin
            chk("if_pc_reset", if_pc, 32'h0);
            chk("if_inst_reset", if_inst, 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; id_stall = 1'b0; br_taken = 1'b0; br_target = '0;
        inst_busy = 1'b0; inst_rdata = '0;
        mem_pend = 1'b0; mem_left = 0; mem_addr = '0; lat = 4; prev_re = 1'b0;
        model_reset();

        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        chk("reset_inst_re", inst_re, 0);
        chk("reset_raddr", inst_raddr, 32'h0);
        chk("reset_if_valid", if_valid, 0);
        chk("reset_if_pc", if_pc, 32'h0);
        chk("reset_if_inst", if_inst, 32'h0);

        // first fetch with decode stalled: queue fills with 0 and 4 and fetching stops
        cycle(1, 1, 0, 0, 0);
        chk("first_re", inst_re, 1);
        chk("first_addr", inst_raddr, 32'h0);
        repeat (30) cycle(1, 1, 0, 0, 0);
        chk("fill_req_count", req_log.size(), 2);
        chk("fill_req0", req_log.size() > 0 ? req_log[0] : 32'hFFFF_FFFF, 32'h0);
        chk("fill_req1", req_log.size() > 1 ? req_log[1] : 32'hFFFF_FFFF, 32'h4);
        chk("fill_head_pc", if_pc, 32'h0);
        chk("fill_head_inst", if_inst, mem_word(32'h0));

        // release stall: 0 then 4 pop, then 8 is fetched
        req_log.delete(); pop_log.delete();
        for (int i = 0; i < 40 && req_log.size() == 0; i++) cycle(1, 0, 0, 0, 0);
        chk("release_pop0", pop_log.size() > 0 ? pop_log[0] : 32'hFFFF_FFFF, 32'h0);
        chk("release_pop1", pop_log.size() > 1 ? pop_log[1] : 32'hFFFF_FFFF, 32'h4);
        chk("release_req", req_log.size() > 0 ? req_log[0] : 32'hFFFF_FFFF, 32'h8);

        // misaligned redirect while 8 is outstanding
        cycle(1, 0, 0, 0, 0);
        pop_log.delete(); req_log.delete();
        cycle(1, 0, 1, 32'h103, 0);
        for (int i = 0; i < 40 && pop_log.size() == 0; i++) cycle(1, 0, 0, 0, 0);
        chk("branch_req", req_log.size() > 0 ? req_log[0] : 32'hFFFF_FFFF, 32'h100);
        chk("branch_first_pc", pop_log.size() > 0 ? pop_log[0] : 32'hFFFF_FFFF, 32'h100);

        // freeze mid-wait
        req_log.delete();
        for (int i = 0; i < 40 && req_log.size() == 0; i++) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0, 0);
        repeat (20) cycle(1, 0, 0, 0, 0);

        // completion coinciding with a pop keeps one entry, head becomes the new word
        cycle(1, 1, 0, 0, 1);
        for (int i = 0; i < 60 && !(m_q.size() == 1 && mem_pend && mem_left == 0); i++)
            cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("pushpop_valid", if_valid, 1);
        chk("pushpop_pc", if_pc, 32'h4);
        chk("pushpop_inst", if_inst, mem_word(32'h4));

        // PC wraps past the top of the address space
        req_log.delete();
        cycle(1, 0, 1, 32'hFFFF_FFFC, 0);
        for (int i = 0; i < 60 && req_log.size() < 2; i++) cycle(1, 0, 0, 0, 0);
        chk("wrap_req0", req_log.size() > 0 ? req_log[0] : 32'h1, 32'hFFFF_FFFC);
        chk("wrap_req1", req_log.size() > 1 ? req_log[1] : 32'h1, 32'h0);

        repeat (3000) begin
            bit          r, st, b, rs;
            logic [31:0] t;
            lat = $urandom_range(0, 4);
            r   = $urandom_range(0, 9) != 0;
            st  = $urandom_range(0, 2) == 0;
            b   = r && ($urandom_range(0, 19) == 0);
            t   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
            rs  = $urandom_range(0, 299) == 0;
            cycle(r, st, b, t, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
